// File: rtl/pma_rx_deser.sv
// pma_rx_deser: serial receive deserializer with K28.5 comma alignment.
// Samples one differential bit per Bit_Rate_Clk cycle into a 10-bit window,
// locks word alignment on a comma, emits one word every 10 cycles while
// locked, realigns after repeated off-boundary commas and drops lock after
// a run of words carrying invalid bits.
// Ports:
//   Bit_Rate_Clk        serial bit clock, all logic on its rising edge
//   Rst_n               asynchronous active-low reset
//   RX_In_P / RX_In_N   differential serial input legs
//   Align_En            enables comma alignment and realignment
//   Data_out[9:0]       deserialized symbol, first-received bit in [0]
//   Data_Valid          one-cycle strobe qualifying Data_out
//   Comma_Det           word is COMMA_N or COMMA_P (with Data_Valid)
//   Code_Err            word contained an invalid bit (with Data_Valid)
//   Comma_Locked        word alignment established
module pma_rx_deser #(
    parameter logic [9:0]  COMMA_N      = 10'h17C,
    parameter logic [9:0]  COMMA_P      = 10'h283,
    parameter int unsigned MISALIGN_MAX = 3,
    parameter int unsigned ERR_MAX      = 4
) (
    input  logic       Bit_Rate_Clk,
    input  logic       Rst_n,
    input  logic       RX_In_P,
    input  logic       RX_In_N,
    input  logic       Align_En,
    output logic [9:0] Data_out,
    output logic       Data_Valid,
    output logic       Comma_Det,
    output logic       Code_Err,
    output logic       Comma_Locked
);

    localparam int unsigned WORD_W   = 10;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LAST_BIT = WORD_W - 1;
    localparam int unsigned MIS_W    = $clog2(MISALIGN_MAX + 1);
    localparam int unsigned ERR_W    = $clog2(ERR_MAX + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  win_q;
    logic [WORD_W-1:0]  inv_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MIS_W-1:0]   mis_q, mis_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic bit_inv_c;
    logic bit_val_c;
    logic win_comma_c;
    logic match_c;
    logic win_err_c;
    logic word_c;

    // Equal legs carry no information: take the bit as 0 and flag it.
    assign bit_inv_c   = (RX_In_P == RX_In_N);
    assign bit_val_c   = RX_In_P & ~bit_inv_c;

    assign win_comma_c = (win_q == COMMA_N) || (win_q == COMMA_P);
    assign match_c     = win_comma_c && (inv_q == '0);
    assign win_err_c   = |inv_q;

    // Next-state, counters and word-boundary decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        err_d   = err_q;
        word_c  = 1'b0;

        case (state_q)
            UNLOCKED: begin
                cnt_d = '0;
                mis_d = '0;
                err_d = '0;
                if (Align_En && match_c) begin
                    word_c  = 1'b1;
                    state_d = LOCKED;
                end
            end

            LOCKED: begin
                if (cnt_q == CNT_W'(LAST_BIT)) begin
                    // Regular boundary: the window holds a complete word.
                    word_c = 1'b1;
                    cnt_d  = '0;
                    if (Align_En && match_c) begin
                        mis_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (Align_En && match_c) begin
                        if (mis_q >= MIS_W'(MISALIGN_MAX - 1)) begin
                            // Enough off-boundary commas: move the boundary here.
                            word_c = 1'b1;
                            cnt_d  = '0;
                            mis_d  = '0;
                        end else begin
                            mis_d = mis_q + MIS_W'(1);
                        end
                    end
                end

                if (!Align_En) begin
                    mis_d = '0;
                end

                // Error run tracking; loss of lock overrides any realignment.
                if (word_c) begin
                    if (win_err_c) begin
                        if (err_q >= ERR_W'(ERR_MAX - 1)) begin
                            state_d = UNLOCKED;
                            cnt_d   = '0;
                            mis_d   = '0;
                            err_d   = '0;
                        end else begin
                            err_d = err_q + ERR_W'(1);
                        end
                    end else begin
                        err_d = '0;
                    end
                end
            end

            default: begin
                state_d = UNLOCKED;
            end
        endcase
    end

    // State, windows, counters and registered outputs.
    always_ff @(posedge Bit_Rate_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= UNLOCKED;
            win_q        <= '0;
            inv_q        <= '0;
            cnt_q        <= '0;
            mis_q        <= '0;
            err_q        <= '0;
            Data_out     <= '0;
            Data_Valid   <= 1'b0;
            Comma_Det    <= 1'b0;
            Code_Err     <= 1'b0;
            Comma_Locked <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= {bit_val_c, win_q[WORD_W-1:1]};
            inv_q        <= {bit_inv_c, inv_q[WORD_W-1:1]};
            cnt_q        <= cnt_d;
            mis_q        <= mis_d;
            err_q        <= err_d;
            Data_Valid   <= word_c;
            Comma_Det    <= word_c & win_comma_c;
            Code_Err     <= word_c & win_err_c;
            Comma_Locked <= (state_d == LOCKED);
            if (word_c) begin
                Data_out <= win_q;
            end
        end
    end

endmodule

// File: tb/tb_pma_rx_deser.sv
// tb_pma_rx_deser: directed bench for pma_rx_deser. Expected words are
// queued when their last bit is driven, with the cycle they must appear on,
// and checked by a monitor whenever Data_Valid is seen.
module tb_pma_rx_deser;

    localparam logic [9:0] K_N = 10'h17C;
    localparam logic [9:0] K_P = 10'h283;

    typedef struct {
        logic [9:0]  data;
        logic        comma;
        logic        err;
        logic        locked;
        int unsigned cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_p;
    logic       rx_n;
    logic       align_en;
    logic [9:0] data_out;
    logic       data_valid;
    logic       comma_det;
    logic       code_err;
    logic       comma_locked;

    exp_t        sb[$];
    int unsigned cyc;
    int          compared;
    int          mismatched;

    logic [9:0]  cw;
    logic [9:0]  rot_fill;
    logic [9:0]  rot_comma;
    logic [9:0]  tail_word;

    pma_rx_deser dut (
        .Bit_Rate_Clk (clk),
        .Rst_n        (rst_n),
        .RX_In_P      (rx_p),
        .RX_In_N      (rx_n),
        .Align_En     (align_en),
        .Data_out     (data_out),
        .Data_Valid   (data_valid),
        .Comma_Det    (comma_det),
        .Code_Err     (code_err),
        .Comma_Locked (comma_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},   data_out, 10'h000);
        chk({tag, "_valid"},  10'(data_valid), 10'h000);
        chk({tag, "_comma"},  10'(comma_det), 10'h000);
        chk({tag, "_err"},    10'(code_err), 10'h000);
        chk({tag, "_locked"}, 10'(comma_locked), 10'h000);
    endtask

    // Drive one bit on the falling edge; an invalid bit sets both legs high.
    task automatic send_bit(input logic b, input logic inv);
        @(negedge clk);
        if (inv) begin
            rx_p = 1'b1;
            rx_n = 1'b1;
        end else begin
            rx_p = b;
            rx_n = ~b;
        end
    endtask

    // Called right after the word's last bit is driven: capture on the next
    // rising edge, registered output one rising edge later.
    task automatic expect_word(input logic [9:0] d, input logic cm, input logic er, input logic lk);
        exp_t e;
        e.data   = d;
        e.comma  = cm;
        e.err    = er;
        e.locked = lk;
        e.cyc    = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [9:0] w, input logic [9:0] inv, input logic expect_it,
                             input logic cm, input logic lk);
        for (int i = 0; i < 10; i++) begin
            send_bit(w[i], inv[i]);
        end
        if (expect_it) begin
            expect_word(w & ~inv, cm, |inv, lk);
        end
    endtask

    // Word sent 3 bits off the locked boundary: the old boundary closes after
    // bit 6; optionally the comma itself becomes the new boundary.
    task automatic send_split(input logic [9:0] w, input logic [9:0] mid, input logic realign);
        for (int i = 0; i < 10; i++) begin
            send_bit(w[i], 1'b0);
            if (i == 6) begin
                expect_word(mid, 1'b0, 1'b0, 1'b1);
            end
            if (i == 9 && realign) begin
                expect_word(w, 1'b1, 1'b0, 1'b1);
            end
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (data_valid === 1'b1) begin
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_valid: observed data=%0h at cycle %0d expected no word",
                       data_out, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                compared++;
                assert (cyc == e.cyc) else begin
                    mismatched++;
                    $error("FAIL word_cycle: observed=%0d expected=%0d", cyc, e.cyc);
                end
                compared++;
                assert (data_out === e.data) else begin
                    mismatched++;
                    $error("FAIL word_data: observed=%0h expected=%0h", data_out, e.data);
                end
                compared++;
                assert (comma_det === e.comma) else begin
                    mismatched++;
                    $error("FAIL word_comma: observed=%0b expected=%0b", comma_det, e.comma);
                end
                compared++;
                assert (code_err === e.err) else begin
                    mismatched++;
                    $error("FAIL word_err: observed=%0b expected=%0b", code_err, e.err);
                end
                compared++;
                assert (comma_locked === e.locked) else begin
                    mismatched++;
                    $error("FAIL word_locked: observed=%0b expected=%0b", comma_locked, e.locked);
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        align_en   = 1'b0;
        rx_p       = 1'b0;
        rx_n       = 1'b1;

        // Rotated views of the comma seen from a boundary 3 bits early.
        cw        = K_N;
        rot_fill  = {cw[6:0], 3'b000};
        rot_comma = {cw[6:0], cw[9:7]};
        tail_word = {7'b0000000, cw[9:7]};

        // Reset state while toggling the line.
        for (int i = 0; i < 4; i++) begin
            send_bit(1'(i % 2), 1'b0);
        end
        chk_all_zero("reset");

        // Initial lock on a comma after idle zeros.
        @(negedge clk);
        rst_n    = 1'b1;
        align_en = 1'b1;
        repeat (20) send_bit(1'b0, 1'b0);
        chk("idle_unlocked", 10'(comma_locked), 10'h000);
        send_word(K_N, 10'h000, 1'b1, 1'b1, 1'b1);

        // Locked data stream.
        send_word(K_P,     10'h000, 1'b1, 1'b1, 1'b1);
        send_word(10'h155, 10'h000, 1'b1, 1'b0, 1'b1);
        send_word(10'h0AA, 10'h000, 1'b1, 1'b0, 1'b1);

        // Shift by 3 bits: third off-boundary comma realigns.
        repeat (3) send_bit(1'b0, 1'b0);
        send_split(K_N, rot_fill,  1'b0);
        send_split(K_N, rot_comma, 1'b0);
        send_split(K_N, rot_comma, 1'b1);
        send_word(K_P, 10'h000, 1'b1, 1'b1, 1'b1);
        chk("realign_locked", 10'(comma_locked), 10'h001);

        // Alignment disabled: off-boundary commas never move the boundary.
        align_en = 1'b0;
        repeat (3) send_bit(1'b0, 1'b0);
        send_split(K_N, rot_fill,  1'b0);
        send_split(K_N, rot_comma, 1'b0);
        send_split(K_N, rot_comma, 1'b0);
        send_split(K_N, rot_comma, 1'b0);
        repeat (6) send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        expect_word(tail_word, 1'b0, 1'b0, 1'b1);
        align_en = 1'b1;
        send_word(10'h155, 10'h000, 1'b1, 1'b0, 1'b1);

        // Four consecutive words with an invalid bit: lock drops on the 4th.
        send_word(10'h155, 10'h001, 1'b1, 1'b0, 1'b1);
        send_word(10'h155, 10'h010, 1'b1, 1'b0, 1'b1);
        send_word(10'h155, 10'h200, 1'b1, 1'b0, 1'b1);
        send_word(10'h155, 10'h004, 1'b1, 1'b0, 1'b0);

        // Comma-valued data carrying an invalid flag must not lock.
        send_word(K_N, 10'h001, 1'b0, 1'b0, 1'b0);
        chk("flagged_comma_unlocked", 10'(comma_locked), 10'h000);
        send_word(K_P, 10'h000, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-word while locked, then no word without a comma.
        repeat (5) send_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midword_reset");
        @(negedge clk);
        rst_n = 1'b1;
        send_word(10'h155, 10'h000, 1'b0, 1'b0, 1'b0);
        send_word(10'h0AA, 10'h000, 1'b0, 1'b0, 1'b0);
        chk("post_reset_unlocked", 10'(comma_locked), 10'h000);

        // Commas with alignment disabled never lock.
        align_en = 1'b0;
        send_word(K_N, 10'h000, 1'b0, 1'b0, 1'b0);
        send_word(K_P, 10'h000, 1'b0, 1'b0, 1'b0);
        send_word(K_N, 10'h000, 1'b0, 1'b0, 1'b0);
        chk("align_off_unlocked", 10'(comma_locked), 10'h000);
        repeat (4) send_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("final_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drained: observed=%0d pending expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
